// File: rtl/alu_unsum_if.sv
// Handshake bundle for the alu_unsum operand-recovery unit: request side
// (valid_i/ready_o/sum_i/b_i) and result side (valid_o/ready_i/a_o/err_o).
interface alu_unsum_if #(
    parameter int nb_bits = 32
);
    logic               valid_i;
    logic               ready_o;
    logic [nb_bits:0]   sum_i;
    logic [nb_bits-1:0] b_i;
    logic               valid_o;
    logic               ready_i;
    logic [nb_bits-1:0] a_o;
    logic               err_o;

    modport master (
        output valid_i, sum_i, b_i, ready_i,
        input  ready_o, valid_o, a_o, err_o
    );

    modport slave (
        input  valid_i, sum_i, b_i, ready_i,
        output ready_o, valid_o, a_o, err_o
    );
endinterface

// File: rtl/alu_unsum.sv
// Chunk-serial operand recovery: a_o = sum_i - b_i, CHUNK bits per cycle, LSB first.
// Optional ALU_UNSUM_ERR_CNT_EN adds a saturating count of errored results (err_cnt_o).
module alu_unsum #(
    parameter int nb_bits = 32,
    parameter int CHUNK   = 8
) (
    input  logic        clock_i,
    input  logic        resetb_i,
    alu_unsum_if.slave  bus
`ifdef ALU_UNSUM_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt_o
`endif
);
    localparam int N     = nb_bits / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [nb_bits-1:0] r_sumSh;
    logic               r_sumTop;
    logic [nb_bits-1:0] r_bSh;
    logic               r_borrow;
    logic [IDX_W-1:0]   r_idx;
    logic [nb_bits-1:0] r_acc;
    logic [nb_bits-1:0] r_a;
    logic               r_err;
    logic [CHUNK:0]     w_diff;
    logic [nb_bits-1:0] w_accNext;
    logic               w_last;
    logic               w_valid;

    // The bit above the chunk in w_diff is the borrow out of this chunk.
    assign w_diff    = {1'b0, r_sumSh[CHUNK-1:0]} - {1'b0, r_bSh[CHUNK-1:0]}
                       - {{CHUNK{1'b0}}, r_borrow};
    assign w_accNext = {w_diff[CHUNK-1:0], r_acc[nb_bits-1:CHUNK]};
    assign w_last    = (r_idx == IDX_W'(N - 1));
    assign w_valid   = (r_state == DONE);

    assign bus.ready_o = (r_state == IDLE);
    assign bus.valid_o = w_valid;
    assign bus.a_o     = r_a;
    assign bus.err_o   = r_err;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.valid_i) w_nextState = BUSY;
            BUSY:    if (w_last) w_nextState = DONE;
            DONE:    if (bus.ready_i) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Operands shift right so the active chunk is always at bit 0; the result
    // builds up in r_acc and is published to r_a only on the last chunk.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state  <= IDLE;
            r_sumSh  <= '0;
            r_sumTop <= 1'b0;
            r_bSh    <= '0;
            r_borrow <= 1'b0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_a      <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (bus.valid_i) begin
                        r_sumSh  <= bus.sum_i[nb_bits-1:0];
                        r_sumTop <= bus.sum_i[nb_bits];
                        r_bSh    <= bus.b_i;
                        r_borrow <= 1'b0;
                        r_idx    <= '0;
                    end
                end
                BUSY: begin
                    r_sumSh  <= r_sumSh >> CHUNK;
                    r_bSh    <= r_bSh >> CHUNK;
                    r_borrow <= w_diff[CHUNK];
                    r_acc    <= w_accNext;
                    r_idx    <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_a   <= w_accNext;
                        r_err <= r_sumTop ^ w_diff[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_UNSUM_ERR_CNT_EN
    logic [7:0] r_errCnt;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_errCnt <= 8'd0;
        end else if (w_valid && bus.ready_i && r_err && (r_errCnt != 8'hFF)) begin
            r_errCnt <= r_errCnt + 8'd1;
        end
    end

    assign err_cnt_o = r_errCnt;
`endif
endmodule

// File: tb/tb_alu_unsum.sv
// Scoreboard bench for alu_unsum: stimulus pushes expected results from a
// plain-arithmetic model; a negedge monitor pops and compares each new result.
module tb_alu_unsum;
    logic clock;
    logic resetb;
    int   total = 0;
    int   bad   = 0;
    logic [32:0] expQ[$];
    logic [32:0] expItem;
    bit   prevValid = 0;

    alu_unsum_if #(.nb_bits(32)) bus ();

`ifdef ALU_UNSUM_ERR_CNT_EN
    logic [7:0] errCnt;
`endif

    alu_unsum #(.nb_bits(32), .CHUNK(8)) dut (
        .clock_i  (clock),
        .resetb_i (resetb),
        .bus      (bus)
`ifdef ALU_UNSUM_ERR_CNT_EN
        ,
        .err_cnt_o(errCnt)
`endif
    );

    initial clock = 0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Unsigned difference computed in wide signed arithmetic, then range-checked.
    function automatic void refModel(input logic [32:0] s, input logic [31:0] b,
                                     output logic [31:0] a, output logic e);
        longint d;
        d = longint'(s) - longint'(b);
        e = (d < 0) || (d > longint'(32'hFFFF_FFFF));
        a = d[31:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [32:0] s, input logic [31:0] b, input bit track);
        int n;
        logic [31:0] ea;
        logic ee;
        n = 0;
        @(negedge clock);
        while (!bus.ready_o && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!bus.ready_o) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: actual=ready_o low required=ready_o high");
            return;
        end
        bus.valid_i = 1'b1;
        bus.sum_i   = s;
        bus.b_i     = b;
        if (track) begin
            refModel(s, b, ea, ee);
            expQ.push_back({ee, ea});
        end
        @(posedge clock);
        #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clock);
        while (!bus.ready_o && n < 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput("idle_reached", 64'(bus.ready_o), 64'd1);
    endtask

    always @(negedge clock) begin
        if (!resetb) begin
            prevValid = 0;
        end else begin
            if (bus.valid_o && !prevValid) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_result: actual=valid_o high required=no result");
                end else begin
                    expItem = expQ.pop_front();
                    checkOutput("result_a", 64'(bus.a_o), 64'(expItem[31:0]));
                    checkOutput("result_err", 64'(bus.err_o), 64'(expItem[32]));
                end
            end
            prevValid = bus.valid_o;
        end
    end

    initial begin
        int lat;
        int n;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [32:0] rs;

        resetb      = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.sum_i   = '0;
        bus.b_i     = '0;
        #25;
        checkOutput("reset_ready", 64'(bus.ready_o), 64'd1);
        checkOutput("reset_valid", 64'(bus.valid_o), 64'd0);
        checkOutput("reset_a", 64'(bus.a_o), 64'd0);
        checkOutput("reset_err", 64'(bus.err_o), 64'd0);
`ifdef ALU_UNSUM_ERR_CNT_EN
        checkOutput("reset_errcnt", 64'(errCnt), 64'd0);
`endif
        @(negedge clock);
        resetb = 1'b1;

        // Case 1 with latency measured in edges after the accept edge.
        applyStimulus(33'h0_0000_0005, 32'h0000_0003, 1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) checkOutput("busy_ready", 64'(bus.ready_o), 64'd0);
            if (bus.valid_o) begin
                lat = k;
                break;
            end
        end
        checkOutput("latency", 64'(lat), 64'd4);

        applyStimulus(33'h1_0000_0000, 32'h0000_0001, 1);
        waitIdle();
`ifdef ALU_UNSUM_ERR_CNT_EN
        checkOutput("errcnt_before", 64'(errCnt), 64'd0);
`endif
        applyStimulus(33'h0_0000_0002, 32'h0000_0005, 1);
        waitIdle();
`ifdef ALU_UNSUM_ERR_CNT_EN
        checkOutput("errcnt_after", 64'(errCnt), 64'd1);
`endif

        // Hold in DONE while new requests are waved at the unit.
        bus.ready_i = 1'b0;
        applyStimulus(33'h0_0000_0001, 32'h0000_0010, 1);
        n = 0;
        @(negedge clock);
        while (!bus.valid_o && n < 20) begin
            @(negedge clock);
            n++;
        end
        checkOutput("hold_valid_seen", 64'(bus.valid_o), 64'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            bus.valid_i = ~bus.valid_i;
            bus.sum_i   = {1'b0, $urandom()};
            bus.b_i     = $urandom();
            #1;
            checkOutput("hold_a", 64'(bus.a_o), 64'h0000_0000_FFFF_FFF1);
            checkOutput("hold_err", 64'(bus.err_o), 64'd1);
            checkOutput("hold_ready", 64'(bus.ready_o), 64'd0);
            checkOutput("hold_valid", 64'(bus.valid_o), 64'd1);
        end
        @(negedge clock);
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("release_valid", 64'(bus.valid_o), 64'd0);
        checkOutput("release_ready", 64'(bus.ready_o), 64'd1);

        // Reset while chunk 2 is being processed; the aborted request is not tracked.
        applyStimulus(33'h0_8765_4321, 32'h1111_1111, 0);
        @(posedge clock);
        @(posedge clock);
        #2;
        resetb = 1'b0;
        #1;
        checkOutput("abort_valid", 64'(bus.valid_o), 64'd0);
        checkOutput("abort_a", 64'(bus.a_o), 64'd0);
        checkOutput("abort_err", 64'(bus.err_o), 64'd0);
`ifdef ALU_UNSUM_ERR_CNT_EN
        checkOutput("abort_errcnt", 64'(errCnt), 64'd0);
`endif
        @(negedge clock);
        resetb = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("abort_ready", 64'(bus.ready_o), 64'd1);
        applyStimulus(33'h0_8765_4321, 32'h1111_1111, 1);

        for (int k = 0; k < 1000; k++) begin
            ra = $urandom();
            rb = $urandom();
            rs = {1'b0, ra} + {1'b0, rb};
            applyStimulus(rs, rb, 1);
        end

        for (int k = 0; k < 200; k++) begin
            rs = {1'($urandom_range(1, 0)), $urandom()};
            rb = $urandom();
            applyStimulus(rs, rb, 1);
        end

        n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        #1;
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
